grf_wb_arbiter: RTL and testbench

- Write-side initiator for the general register file. Merges two result sources into the GRF's single write port (RegWrite/WA/WD/PC0):
  - the in-order pipeline writeback stream (source A);
  - the multi-cycle mult/div result stream (source B).
- Buffers colliding B results in a small FIFO and keeps write-after-write order correct.
- Exports a pending-register mask so decode can stall reads of registers whose values are still queued.

---
 rtl/grf_pkg.sv | 17 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/grf_wb_arbiter.sv | 114 +++++++++++
 tb/tb_grf_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared types and helpers for the GRF write-side arbiter and its result FIFO.
package grf_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic        valid;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] pc;
   } wb_entry_t;

   function automatic logic [31:0] onehot32(input logic [4:0] wa);
      return 32'd1 << wa;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of B write results with per-entry squash by destination register
// and a register-indexed mask of the still-valid entries.
module wb_fifo
   import grf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  wb_entry_t   i_pushEntry,
   input  logic        i_pop,
   input  logic        i_squash,
   input  logic [4:0]  i_squashWa,
   output wb_entry_t   o_head,
   output logic        o_empty,
   output logic        o_full,
   output logic [31:0] o_pendMask
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [PW:0]   r_count;

   assign o_head  = r_mem[r_rdPtr];
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_FULL);

   // Squash clears only the valid bit; the slot stays occupied until it is popped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_squash) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_mem[i].valid && (r_mem[i].wa == i_squashWa)) begin
                  r_mem[i].valid <= 1'b0;
               end
            end
         end
         if (i_pop) begin
            r_mem[r_rdPtr].valid <= 1'b0;
            r_rdPtr              <= r_rdPtr + 1'b1;
         end
         if (i_push) begin
            r_mem[r_wrPtr] <= i_pushEntry;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
      end
   end

   always_comb begin
      o_pendMask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_mem[i].valid) begin
            o_pendMask = o_pendMask | onehot32(r_mem[i].wa);
         end
      end
      o_pendMask[0] = 1'b0;
   end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline writeback (A) wins, mult/div results (B) bypass or queue,
// stale queued B results are squashed on write-after-write, and a starving queue stalls A.
module grf_wb_arbiter
   import grf_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   input  logic [4:0]  a_wa,
   input  logic [31:0] a_wd,
   input  logic [31:0] a_pc,
   output logic        a_stall,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_wa,
   input  logic [31:0] b_wd,
   input  logic [31:0] b_pc,
   output logic        RegWrite,
   output logic [4:0]  WA,
   output logic [31:0] WD,
   output logic [31:0] PC0,
   output logic [31:0] pend_mask
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

   logic          r_stall;
   logic [SW-1:0] r_starve;
   logic [SW-1:0] w_starveNext;
   logic          w_aSel;
   logic          w_bAccept;
   logic          w_bKeep;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic          w_fifoEmpty;
   logic          w_fifoFull;
   wb_entry_t     w_head;
   wb_entry_t     w_bEntry;

   assign a_stall   = r_stall;
   assign b_ready   = !w_fifoFull;
   assign w_aSel    = a_valid && (a_wa != REG_ZERO) && !r_stall;
   assign w_bAccept = b_valid && !w_fifoFull;
   // A B result to the register A is writing now is older than A, so it is simply dropped.
   assign w_bKeep   = w_bAccept && (b_wa != REG_ZERO) && !(w_aSel && (b_wa == a_wa));
   assign w_pop     = !w_aSel && !w_fifoEmpty;
   assign w_bypass  = w_bKeep && !w_aSel && w_fifoEmpty;
   assign w_push    = w_bKeep && !w_bypass;
   assign w_bEntry  = '{valid: 1'b1, wa: b_wa, wd: b_wd, pc: b_pc};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_pushEntry (w_bEntry),
      .i_pop       (w_pop),
      .i_squash    (w_aSel),
      .i_squashWa  (a_wa),
      .o_head      (w_head),
      .o_empty     (w_fifoEmpty),
      .o_full      (w_fifoFull),
      .o_pendMask  (pend_mask)
   );

   always_comb begin
      w_starveNext = r_starve;
      if (w_fifoEmpty || w_pop) begin
         w_starveNext = '0;
      end else if (w_aSel && w_head.valid && (r_starve != STARVE_LIMIT)) begin
         w_starveNext = r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         RegWrite <= 1'b0;
         WA       <= REG_ZERO;
         WD       <= '0;
         PC0      <= '0;
         r_stall  <= 1'b0;
         r_starve <= '0;
      end else begin
         r_starve <= w_starveNext;
         r_stall  <= (w_starveNext == STARVE_LIMIT);
         RegWrite <= 1'b0;
         if (w_aSel) begin
            RegWrite <= 1'b1;
            WA       <= a_wa;
            WD       <= a_wd;
            PC0      <= a_pc;
         end else if (w_pop) begin
            if (w_head.valid) begin
               RegWrite <= 1'b1;
               WA       <= w_head.wa;
               WD       <= w_head.wd;
               PC0      <= w_head.pc;
            end
         end else if (w_bypass) begin
            RegWrite <= 1'b1;
            WA       <= b_wa;
            WD       <= b_wd;
            PC0      <= b_pc;
         end
      end
   end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model of the write port.
module tb_grf_wb_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        a_valid = 1'b0;
   logic [4:0]  a_wa = '0;
   logic [31:0] a_wd = '0;
   logic [31:0] a_pc = '0;
   logic        a_stall;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [4:0]  b_wa = '0;
   logic [31:0] b_wd = '0;
   logic [31:0] b_pc = '0;
   logic        RegWrite;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic [31:0] PC0;
   logic [31:0] pend_mask;

   grf_wb_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_wa      (a_wa),
      .a_wd      (a_wd),
      .a_pc      (a_pc),
      .a_stall   (a_stall),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_wa      (b_wa),
      .b_wd      (b_wd),
      .b_pc      (b_pc),
      .RegWrite  (RegWrite),
      .WA        (WA),
      .WD        (WD),
      .PC0       (PC0),
      .pend_mask (pend_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        valid;
      bit [4:0]  wa;
      bit [31:0] wd;
      bit [31:0] pc;
   } ent_t;

   // Reference model: queued B results in arrival order plus the visible write-port state.
   ent_t      mQ[$];
   int        mStarve = 0;
   bit        mStall = 1'b0;
   bit        mAcc = 1'b0;
   bit        mRegWrite = 1'b0;
   bit [4:0]  mWa = '0;
   bit [31:0] mWd = '0;
   bit [31:0] mPc = '0;

   bit        bPend = 1'b0;
   bit [4:0]  bWa = '0;
   bit [31:0] bWd = '0;
   bit [31:0] bPc = '0;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s got=%h want=%h t=%0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit [31:0] modelPend();
      bit [31:0] m = '0;
      foreach (mQ[i]) begin
         if (mQ[i].valid) m[mQ[i].wa] = 1'b1;
      end
      return m;
   endfunction

   task automatic modelWrite(input bit [4:0] wa, input bit [31:0] wd, input bit [31:0] pc);
      mRegWrite = 1'b1;
      mWa = wa;
      mWd = wd;
      mPc = pc;
   endtask

   task automatic modelStep();
      bit   aSel;
      bit   popNow;
      bit   headValid;
      bit   bKeep;
      bit   bypassed;
      int   newStarve;
      ent_t h;
      ent_t e;
      mAcc = 1'b0;
      if (!reset) begin
         mQ.delete();
         mStarve = 0;
         mStall = 1'b0;
         mRegWrite = 1'b0;
         mWa = '0;
         mWd = '0;
         mPc = '0;
         return;
      end
      mAcc      = b_valid && (mQ.size() < DEPTH);
      aSel      = a_valid && (a_wa != 5'd0) && !mStall;
      popNow    = !aSel && (mQ.size() > 0);
      headValid = (mQ.size() > 0) && mQ[0].valid;
      if ((mQ.size() == 0) || popNow) newStarve = 0;
      else if (aSel && headValid) newStarve = (mStarve < STARVE_MAX) ? mStarve + 1 : mStarve;
      else newStarve = mStarve;
      bKeep     = mAcc && (b_wa != 5'd0) && !(aSel && (b_wa == a_wa));
      bypassed  = 1'b0;
      mRegWrite = 1'b0;
      if (aSel) begin
         modelWrite(a_wa, a_wd, a_pc);
         foreach (mQ[i]) begin
            if (mQ[i].wa == a_wa) mQ[i].valid = 1'b0;
         end
      end else if (popNow) begin
         h = mQ.pop_front();
         if (h.valid) modelWrite(h.wa, h.wd, h.pc);
      end else if (bKeep) begin
         bypassed = 1'b1;
         modelWrite(b_wa, b_wd, b_pc);
      end
      if (bKeep && !bypassed) begin
         e.valid = 1'b1;
         e.wa = b_wa;
         e.wd = b_wd;
         e.pc = b_pc;
         mQ.push_back(e);
      end
      mStarve = newStarve;
      mStall  = (mStarve >= STARVE_MAX);
   endtask

   task automatic queueB(input bit [4:0] wa, input bit [31:0] wd, input bit [31:0] pc);
      bPend = 1'b1;
      bWa = wa;
      bWd = wd;
      bPc = pc;
   endtask

   // One clock: drive inputs (A held off while the model says stalled), advance the model, compare.
   task automatic applyStimulus(input bit rst, input bit aV, input bit [4:0] aWa, input bit [31:0] aWd, input bit [31:0] aPc);
      reset   = rst;
      a_valid = aV && !mStall;
      a_wa    = aWa;
      a_wd    = aWd;
      a_pc    = aPc;
      b_valid = bPend;
      b_wa    = bWa;
      b_wd    = bWd;
      b_pc    = bPc;
      if (rst) checkOutput("a_valid_under_stall", 32'(a_stall & a_valid), 32'd0);
      modelStep();
      if (mAcc) bPend = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("RegWrite", 32'(RegWrite), 32'(mRegWrite));
      checkOutput("WA", 32'(WA), 32'(mWa));
      checkOutput("WD", WD, mWd);
      checkOutput("PC0", PC0, mPc);
      checkOutput("a_stall", 32'(a_stall), 32'(mStall));
      checkOutput("b_ready", 32'(b_ready), 32'(mQ.size() < DEPTH));
      checkOutput("pend_mask", pend_mask, modelPend());
   endtask

   task automatic idle();
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234, 32'h400);
         checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
      end
      checkOutput("rst_pend", pend_mask, 32'd0);
      applyStimulus(1'b1, 1'b1, 5'd5, 32'h1234, 32'h400);
      checkOutput("rst_release_wa", 32'(WA), 32'd5);
      checkOutput("rst_release_wd", WD, 32'h1234);

      queueB(5'd8, 32'hDEAD, 32'h800);
      idle();
      checkOutput("bonly_write", 32'(RegWrite), 32'd1);
      checkOutput("bonly_wa", 32'(WA), 32'd8);
      checkOutput("bonly_wd", WD, 32'hDEAD);
      checkOutput("bonly_pend", pend_mask, 32'd0);

      queueB(5'd9, 32'd2, 32'h900);
      applyStimulus(1'b1, 1'b1, 5'd3, 32'd1, 32'h300);
      checkOutput("coll_first_wa", 32'(WA), 32'd3);
      checkOutput("coll_pend9", pend_mask, 32'h0000_0200);
      idle();
      checkOutput("coll_second_wa", 32'(WA), 32'd9);
      checkOutput("coll_second_wd", WD, 32'd2);
      checkOutput("coll_pend_clear", pend_mask, 32'd0);

      queueB(5'd7, 32'hBB, 32'h700);
      applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 32'h104);
      applyStimulus(1'b1, 1'b1, 5'd2, 32'h22, 32'h108);
      checkOutput("waw_pend7_set", 32'(pend_mask[7]), 32'd1);
      applyStimulus(1'b1, 1'b1, 5'd7, 32'hAA, 32'h10C);
      checkOutput("waw_pend7_clear", 32'(pend_mask[7]), 32'd0);
      idle();
      checkOutput("waw_silent_pop", 32'(RegWrite), 32'd0);
      checkOutput("waw_final_wd", WD, 32'hAA);

      queueB(5'd20, 32'hB20, 32'h2000);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 5'(1 + i), 32'(i), 32'h200 + 32'(4 * i));
      checkOutput("starve_stall_up", 32'(a_stall), 32'd1);
      applyStimulus(1'b1, 1'b1, 5'd6, 32'h66, 32'h300);
      checkOutput("starve_b_wa", 32'(WA), 32'd20);
      checkOutput("starve_stall_down", 32'(a_stall), 32'd0);

      queueB(5'd10, 32'hA10, 32'h1000);
      applyStimulus(1'b1, 1'b1, 5'd1, 32'h1, 32'h500);
      queueB(5'd11, 32'hA11, 32'h1100);
      applyStimulus(1'b1, 1'b1, 5'd2, 32'h2, 32'h504);
      checkOutput("full_b_ready", 32'(b_ready), 32'd0);
      queueB(5'd12, 32'hA12, 32'h1200);
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h3, 32'h508);
      checkOutput("full_pend", pend_mask, 32'h0000_0C00);
      applyStimulus(1'b1, 1'b1, 5'd0, 32'hFF, 32'h50C);
      checkOutput("full_a_zero_pops_wa", 32'(WA), 32'd10);
      idle();
      idle();
      idle();
      applyStimulus(1'b1, 1'b1, 5'd0, 32'hEE, 32'h600);
      checkOutput("a_zero_no_write", 32'(RegWrite), 32'd0);
      queueB(5'd0, 32'hCC, 32'h610);
      idle();
      checkOutput("b_zero_no_write", 32'(RegWrite), 32'd0);

      queueB(5'd14, 32'hE14, 32'h1400);
      applyStimulus(1'b1, 1'b1, 5'd4, 32'h4, 32'h700);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      checkOutput("midrst_pend", pend_mask, 32'd0);
      checkOutput("midrst_regwrite", 32'(RegWrite), 32'd0);
      idle();
      checkOutput("midrst_no_write", 32'(RegWrite), 32'd0);

      for (int n = 0; n < 3000; n++) begin
         if (!bPend && ($urandom_range(0, 9) < 4))
            queueB(5'($urandom_range(0, 7)), $urandom, $urandom);
         applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1),
                       5'($urandom_range(0, 7)), $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
